// File: rtl/mem_stage_pkg.sv
// Shared widths, load-type encodings, bus layouts and the FSM state type
// for the memory-access pipeline stage.
package mem_stage_pkg;

    // Inter-stage bus widths.
    localparam int ES_TO_MS_BUS_WD = 74;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_TO_ID_BYPASS = 39;

    // Load-type encodings carried on the execute-stage bus.
    localparam logic [2:0] LD_LW    = 3'b000;
    localparam logic [2:0] LD_LB    = 3'b001;
    localparam logic [2:0] LD_LBU   = 3'b010;
    localparam logic [2:0] LD_LH    = 3'b011;
    localparam logic [2:0] LD_LHU   = 3'b100;
    localparam logic [2:0] LD_NONE  = 3'b110;
    localparam logic [2:0] LD_STORE = 3'b111;

    // Per-instruction state: IDLE = nothing outstanding, WAIT = response owed.
    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } ms_state_t;

    typedef struct packed {
        logic [2:0]  ld_type;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_bus_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_bus_t;

    typedef struct packed {
        logic        fwd_we;
        logic        load_pending;
        logic [4:0]  dest;
        logic [31:0] final_result;
    } ms_to_id_bypass_t;

    // Plain ALU ops arrive as ld_type=LW with res_from_mem=0; anything else
    // (loads, stores) issued a data request whose data_ok must be waited for.
    function automatic logic needs_response(input logic [2:0] ld_type,
                                            input logic       res_from_mem);
        return (ld_type != LD_LW) || res_from_mem;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load alignment: selects the byte/halfword addressed by the
// low address bits and sign- or zero-extends it; words pass straight through.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Split the response word into byte lanes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata[gi*8 +: 8];
    end

    assign byte_sel = lane[addr];
    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    // Extension per load type; stores/none fall through as a full word.
    always_comb begin
        result = rdata;
        case (ld_type)
            LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  result = {24'h0, byte_sel};
            LD_LH:   result = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction from execute, waits for the
// data-SRAM response of loads/stores, buffers read data that arrives while
// write-back is stalled, and drives the write-back and forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_ID_BYPASS-1:0] ms_to_id_bypass
);

    es_to_ms_bus_t    es_bus;
    es_to_ms_bus_t    bus_reg;
    logic             ms_valid_reg;
    ms_state_t        state_reg;
    logic [31:0]      rdata_buf_reg;

    logic             resp_ok;
    logic             ms_ready_go;
    logic             accept;
    logic [31:0]      load_rdata;
    logic [31:0]      load_result;
    logic [31:0]      final_result;
    logic             load_pending;
    ms_to_ws_bus_t    ws_bus;
    ms_to_id_bypass_t id_bypass;

    assign es_bus = es_to_ms_bus;

    // A response only counts while an instruction is actually waiting for it;
    // stray pulses are a protocol error and are ignored here.
    assign resp_ok        = data_sram_data_ok && ms_valid_reg && (state_reg == MS_WAIT);
    assign ms_ready_go    = (state_reg == MS_IDLE) || resp_ok;
    assign ms_allowin     = !ms_valid_reg || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_reg && ms_ready_go;
    assign accept         = es_to_ms_valid && ms_allowin;

    // Occupancy and wait state; a new instruction sets its own entry state,
    // otherwise a response moves a stalled instruction to IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_reg <= 1'b0;
            state_reg    <= MS_IDLE;
        end else if (ms_allowin) begin
            ms_valid_reg <= es_to_ms_valid;
            state_reg    <= (es_to_ms_valid &&
                             needs_response(es_bus.ld_type, es_bus.res_from_mem))
                            ? MS_WAIT : MS_IDLE;
        end else if (resp_ok) begin
            state_reg <= MS_IDLE;
        end
    end

    // Instruction payload latch; qualified by ms_valid so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            bus_reg <= es_bus;
        end
    end

    // Keep read data that arrives while write-back cannot take the result.
    always_ff @(posedge clk) begin
        if (resp_ok && !ws_allowin) begin
            rdata_buf_reg <= data_sram_rdata;
        end
    end

    assign load_rdata = resp_ok ? data_sram_rdata : rdata_buf_reg;

    mem_load_align u_align (
        .ld_type (bus_reg.ld_type),
        .addr    (bus_reg.alu_result[1:0]),
        .rdata   (load_rdata),
        .result  (load_result)
    );

    assign final_result = bus_reg.res_from_mem ? load_result : bus_reg.alu_result;
    assign load_pending = ms_valid_reg && bus_reg.res_from_mem && !ms_ready_go;

    assign ws_bus = '{gr_we:        bus_reg.gr_we,
                      dest:         bus_reg.dest,
                      final_result: final_result,
                      pc:           bus_reg.pc};

    assign id_bypass = '{fwd_we:       ms_valid_reg && bus_reg.gr_we,
                         load_pending: load_pending,
                         dest:         bus_reg.dest,
                         final_result: final_result};

    assign ms_to_ws_bus    = ws_bus;
    assign ms_to_id_bypass = id_bypass;

    // data_ok must only ever answer an instruction that is waiting.
    data_ok_expected: assert property (@(posedge clk) disable iff (!resetn)
        data_sram_data_ok |-> (ms_valid_reg && state_reg == MS_WAIT));

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a stimulus process issues instructions and answers
// data requests; expected results are queued on acceptance and a separate
// monitor compares every presented result plus per-cycle handshake state.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] ms_to_id_bypass;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_id_bypass   (ms_to_id_bypass)
    );

    localparam int K_LW = 0, K_LB = 1, K_LBU = 2, K_LH = 3, K_LHU = 4;
    localparam int K_STORE = 7, K_ALU = 8;

    typedef struct {
        logic [2:0]  ld;
        bit          rfm;
        bit          gr_we;
        bit          mem_op;
        logic [4:0]  dest;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] rdata;
        int          resp_delay;
        int          hold;
    } instr_t;

    typedef struct {
        bit          gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } exp_t;

    instr_t      stim_q[$];
    exp_t        exp_q[$];
    instr_t      es_cur;
    instr_t      mem_cur;
    bit          es_hold, occ, resp_pend, rand_ws, rand_gap, chk_en;
    int          resp_cnt, hold_cnt;
    int          n_tests, n_fail, out_count, pend_cycles;
    logic [31:0] last_result;
    logic [31:0] pc_ctr;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load semantics from plain shift/mask arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] ld, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int unsigned w, b, h;
        w = rdata;
        b = (w >> (8 * addr[1:0])) & 32'hFF;
        h = (w >> (16 * addr[1])) & 32'hFFFF;
        case (ld)
            3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    function automatic instr_t mk(input int kind, input logic [31:0] addr,
                                  input logic [31:0] rdata, input int dly, input int hold);
        instr_t t;
        t.addr       = addr;
        t.rdata      = rdata;
        t.resp_delay = dly;
        t.hold       = hold;
        t.dest       = 5'($urandom_range(1, 31));
        t.pc         = pc_ctr;
        pc_ctr       = pc_ctr + 32'd4;
        if (kind == K_ALU) begin
            t.ld = 3'd0; t.rfm = 1'b0; t.gr_we = 1'($urandom_range(0, 1)); t.mem_op = 1'b0;
        end else if (kind == K_STORE) begin
            t.ld = 3'd7; t.rfm = 1'b0; t.gr_we = 1'b0; t.mem_op = 1'b1;
        end else begin
            t.ld = 3'(kind); t.rfm = 1'b1; t.gr_we = 1'b1; t.mem_op = 1'b1;
        end
        return t;
    endfunction

    // One clock of stimulus: drive after the rising edge, update the model mid-cycle.
    task automatic cycle();
        bit   was_occ, leave;
        exp_t e;
        @(posedge clk);
        #1;
        data_sram_data_ok = occ && resp_pend && (resp_cnt == 0);
        data_sram_rdata   = data_sram_data_ok ? mem_cur.rdata : $urandom;
        if (data_sram_data_ok && mem_cur.hold > 0) hold_cnt = mem_cur.hold;
        if (hold_cnt > 0) begin
            ws_allowin = 1'b0;
            hold_cnt--;
        end else begin
            ws_allowin = rand_ws ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (!es_hold && stim_q.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
            es_cur  = stim_q.pop_front();
            es_hold = 1'b1;
        end
        es_to_ms_valid = es_hold;
        if (es_hold)
            es_to_ms_bus = {es_cur.ld, es_cur.rfm, es_cur.gr_we, es_cur.dest, es_cur.addr, es_cur.pc};
        @(negedge clk);
        #2;
        was_occ = occ;
        leave   = occ && (!resp_pend || data_sram_data_ok) && ws_allowin;
        if (data_sram_data_ok) resp_pend = 1'b0;
        else if (resp_pend && resp_cnt > 0) resp_cnt--;
        if (leave) occ = 1'b0;
        if (es_hold && (!was_occ || leave)) begin
            mem_cur   = es_cur;
            es_hold   = 1'b0;
            occ       = 1'b1;
            resp_pend = es_cur.mem_op;
            resp_cnt  = es_cur.resp_delay;
            e.gr_we   = es_cur.gr_we;
            e.dest    = es_cur.dest;
            e.result  = es_cur.rfm ? ref_load(es_cur.ld, es_cur.addr, es_cur.rdata) : es_cur.addr;
            e.pc      = es_cur.pc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input int budget, input string tag);
        int k;
        k = 0;
        while ((stim_q.size() > 0 || es_hold || occ) && k < budget) begin
            cycle();
            k++;
        end
        if (stim_q.size() > 0 || es_hold || occ) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_%s: still busy after %0d cycles, required idle", tag, budget);
            stim_q.delete(); exp_q.delete();
            es_hold = 0; occ = 0; resp_pend = 0; hold_cnt = 0;
        end
        cycle();
    endtask

    // Monitor: per-cycle handshake checks and scoreboard pops on transfers.
    initial begin
        bit   exp_valid;
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_valid = occ && (!resp_pend || data_sram_data_ok);
                chk("ms_to_ws_valid", 70'(ms_to_ws_valid), 70'(exp_valid));
                chk("ms_allowin", 70'(ms_allowin), 70'(!occ || (exp_valid && ws_allowin)));
                chk("bypass_we", 70'(ms_to_id_bypass[38]), 70'(occ && mem_cur.gr_we));
                chk("load_pending", 70'(ms_to_id_bypass[37]),
                    70'(occ && mem_cur.rfm && resp_pend && !data_sram_data_ok));
                if (ms_to_id_bypass[37]) pend_cycles++;
                if (ms_to_ws_valid) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_empty: got result %h with nothing expected", ms_to_ws_bus);
                    end else begin
                        e = exp_q[0];
                        chk("ws_bus", ms_to_ws_bus, {e.gr_we, e.dest, e.result, e.pc});
                        chk("bypass_data", 70'(ms_to_id_bypass[36:0]), 70'({e.dest, e.result}));
                        if (ws_allowin) begin
                            exp_q.delete(0);
                            out_count++;
                            last_result = ms_to_ws_bus[63:32];
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, pc0, kind;
        logic [31:0] a;
        n_tests = 0; n_fail = 0; out_count = 0; pend_cycles = 0;
        es_hold = 0; occ = 0; resp_pend = 0; resp_cnt = 0; hold_cnt = 0;
        rand_ws = 0; rand_gap = 0; chk_en = 0; pc_ctr = 32'hBFC0_0000; last_result = '0;
        ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1;
        chk("rst_valid", 70'(ms_to_ws_valid), 70'(0));
        chk("rst_allowin", 70'(ms_allowin), 70'(1));
        chk("rst_bypass_we", 70'(ms_to_id_bypass[38]), 70'(0));
        chk("rst_load_pending", 70'(ms_to_id_bypass[37]), 70'(0));
        #10 resetn = 1'b1;
        chk_en = 1'b1;

        base = out_count;
        stim_q.push_back(mk(K_ALU, 32'h1234_5678, 32'h0, 0, 0));
        drain(50, "alu");
        chk("alu_result", 70'(last_result), 70'(32'h1234_5678));
        chk("alu_count", 70'(out_count - base), 70'(1));

        pc0 = pend_cycles;
        stim_q.push_back(mk(K_LB, 32'h0000_1003, 32'h80AA_BBCC, 2, 0));
        drain(50, "lb");
        chk("lb_result", 70'(last_result), 70'(32'hFFFF_FF80));
        chk("lb_pending_cycles", 70'(pend_cycles - pc0), 70'(2));

        stim_q.push_back(mk(K_LBU, 32'h0000_1003, 32'h80AA_BBCC, 2, 0));
        drain(50, "lbu");
        chk("lbu_result", 70'(last_result), 70'(32'h0000_0080));

        stim_q.push_back(mk(K_LH, 32'h0000_2002, 32'h8001_7FFF, 1, 0));
        drain(50, "lh");
        chk("lh_result", 70'(last_result), 70'(32'hFFFF_8001));

        stim_q.push_back(mk(K_LHU, 32'h0000_2000, 32'h8001_7FFF, 0, 0));
        drain(50, "lhu");
        chk("lhu_result", 70'(last_result), 70'(32'h0000_7FFF));

        base = out_count;
        stim_q.push_back(mk(K_LW, 32'h0000_3000, 32'hDEAD_BEEF, 1, 3));
        drain(50, "lw_hold");
        chk("lw_hold_result", 70'(last_result), 70'(32'hDEAD_BEEF));
        chk("lw_hold_count", 70'(out_count - base), 70'(1));

        base = out_count;
        stim_q.push_back(mk(K_STORE, 32'h0000_4004, 32'h1111_2222, 0, 0));
        stim_q.push_back(mk(K_LW, 32'h0000_4008, 32'h0BAD_F00D, 1, 0));
        drain(50, "store_load");
        chk("store_load_count", 70'(out_count - base), 70'(2));
        chk("store_load_result", 70'(last_result), 70'(32'h0BAD_F00D));

        base = out_count;
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 6);
            if (kind == 5) kind = K_STORE;
            if (kind == 6) kind = K_ALU;
            a = $urandom;
            if (kind == K_LW) a[1:0] = 2'b00;
            if (kind == K_LH || kind == K_LHU) a[0] = 1'b0;
            stim_q.push_back(mk(kind, a, $urandom, $urandom_range(0, 4),
                                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0));
        end
        rand_ws = 1; rand_gap = 1;
        drain(6000, "random");
        chk("random_count", 70'(out_count - base), 70'(300));

        rand_ws = 0; rand_gap = 0;
        base = out_count;
        stim_q.push_back(mk(K_LW, 32'h0000_5000, 32'h5555_AAAA, 40, 0));
        cycle(); cycle(); cycle();
        chk("pre_reset_pending", 70'(ms_to_id_bypass[37]), 70'(1));
        resetn = 1'b0;
        #1;
        chk("async_rst_valid", 70'(ms_to_ws_valid), 70'(0));
        chk("async_rst_allowin", 70'(ms_allowin), 70'(1));
        chk("async_rst_pending", 70'(ms_to_id_bypass[37]), 70'(0));
        occ = 0; resp_pend = 0; es_hold = 0; hold_cnt = 0; exp_q.delete();
        cycle(); cycle();
        resetn = 1'b1;
        stim_q.push_back(mk(K_ALU, 32'hCAFE_F00D, 32'h0, 0, 0));
        drain(50, "post_reset");
        chk("post_reset_result", 70'(last_result), 70'(32'hCAFE_F00D));
        chk("post_reset_count", 70'(out_count - base), 70'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
